mcycle_ctrl_v2: RTL and testbench

MCYCLE_CTRL_V2 -- requirements
Module: mcycle_ctrl_v2

---
 rtl/mcycle_pkg.sv | 80 ++++++++
 rtl/mcycle_aludec.sv | 33 +++
 rtl/mcycle_ctrl_v2.sv | 215 +++++++++++++++++++++
 tb/tb_mcycle_ctrl_v2.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states,
// ALU control codes and datapath mux selects.
package mcycle_pkg;

    typedef enum logic [6:0] {
        OP_R    = 7'b0110011,
        OP_IALU = 7'b0010011,
        OP_LW   = 7'b0000011,
        OP_SW   = 7'b0100011,
        OP_BR   = 7'b1100011,
        OP_JAL  = 7'b1101111,
        OP_JALR = 7'b1100111,
        OP_LUI  = 7'b0110111
    } opcode_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_LUI      = 4'd11,
        S_BRANCH   = 4'd12,
        S_TRAP     = 4'd13,
        S_JALR2    = 4'd14
    } state_e;

    // How the ALU operation is chosen in a given state.
    typedef enum logic [1:0] {
        ALUM_ADD   = 2'd0,
        ALUM_SUB   = 2'd1,
        ALUM_FUNCT = 2'd2
    } alu_mode_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            OP_LUI:  return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mcycle_aludec.sv
// Combinational ALU operation decode from the FSM's ALU mode and funct fields.
module mcycle_aludec
    import mcycle_pkg::*;
(
    input  alu_mode_e   alu_mode,
    input  logic        op5,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [3:0]  alu_control
);

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_mode)
            ALUM_SUB: alu_control = ALU_SUB;
            ALUM_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mcycle_ctrl_v2.sv
// Multicycle RISC-V control FSM with memory-wait timeout and fault register.
// Define MCTRL_BRANCH_EXT_EN to add bne/blt/bge on top of beq.
module mcycle_ctrl_v2
    import mcycle_pkg::*;
#(
    parameter int MAX_WAIT  = 15,
    parameter int TRAP_HALT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        Lt,
    input  logic        MemReady,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic        AdrSrc,
    output logic [3:0]  ALUControl,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemReq,
    output logic        Fault
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        fault_q, fault_d;
    alu_mode_e   alu_mode;
    logic        br_legal, br_taken, mem_wait_state;

`ifdef MCTRL_BRANCH_EXT_EN
    always_comb begin
        br_legal = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
        case (funct3)
            3'b001:  br_taken = ~Zero;
            3'b100:  br_taken = Lt;
            3'b101:  br_taken = ~Lt;
            default: br_taken = Zero;
        endcase
    end
`else
    logic unused_lt;
    assign unused_lt = Lt;
    assign br_legal  = (funct3 == 3'b000);
    assign br_taken  = Zero;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady)                state_d = S_DECODE;
                else if (wait_q == WAIT_LAST) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_IALU:      state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    OP_BR:        state_d = br_legal ? S_BRANCH : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (MemReady)                state_d = S_MEMWB;
                else if (wait_q == WAIT_LAST) state_d = S_TRAP;
            end
            S_MEMWRITE: begin
                if (MemReady)                state_d = S_FETCH;
                else if (wait_q == WAIT_LAST) state_d = S_TRAP;
            end
            S_EXECR, S_EXECI, S_JAL, S_LUI:      state_d = S_ALUWB;
            S_JALR:                              state_d = S_JALR2;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JALR2: state_d = S_FETCH;
            S_TRAP:  state_d = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
            default: state_d = S_FETCH;
        endcase

        // The counter restarts on every state entry, so each access gets a fresh budget.
        mem_wait_state = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
        if (state_d != state_q)              wait_d = '0;
        else if (mem_wait_state && !MemReady) wait_d = wait_q + 8'd1;
        else                                  wait_d = wait_q;

        if (TRAP_HALT != 0) fault_d = fault_q | (state_d == S_TRAP);
        else                fault_d = (state_d == S_TRAP);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        ImmSrc    = imm_src_of(op);
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        alu_mode  = ALUM_ADD;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        MemReq    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA  = SRCA_RD1;
                alu_mode = ALUM_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_IMM;
                alu_mode = ALUM_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_I;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
            end
            S_JALR2: begin
                // Link value OldPC+4 is written straight from the ALU result.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                RegWrite  = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_RD1;
                alu_mode = ALUM_SUB;
                PCWrite  = br_taken;
            end
            default: ;
        endcase
        if (reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemReq   = 1'b0;
        end
    end

    assign Fault = fault_q;

    mcycle_aludec u_aludec (
        .alu_mode    (alu_mode),
        .op5         (op[5]),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_mcycle_ctrl_v2.sv
// Directed scoreboard bench for mcycle_ctrl_v2 (MAX_WAIT=4, TRAP_HALT=1).
module tb_mcycle_ctrl_v2;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;

    logic        clk, reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, Zero, Lt, MemReady;
    logic [2:0]  ImmSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic        AdrSrc;
    logic [3:0]  ALUControl;
    logic        IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Fault;

    typedef struct {
        string       tag;
        logic [19:0] v;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [19:0] obs_v;

    assign obs_v = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                    IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Fault};

    mcycle_ctrl_v2 #(.MAX_WAIT(4), .TRAP_HALT(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .MemReady(MemReady), .ImmSrc(ImmSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc),
        .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemReq(MemReq), .Fault(Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] ov(input logic [2:0] imm, input logic [1:0] sa,
                                       input logic [1:0] sbs, input logic [1:0] rs,
                                       input logic adr, input logic [3:0] alu,
                                       input logic ir, input logic pc, input logic rw,
                                       input logic mw, input logic mr, input logic f);
        return {imm, sa, sbs, rs, adr, alu, ir, pc, rw, mw, mr, f};
    endfunction

    function automatic logic [19:0] v_fetch(input logic [2:0] imm, input logic rdy);
        return ov(imm, 2'b00, 2'b10, 2'b10, 1'b0, ADD, rdy, rdy, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic logic [19:0] v_decode(input logic [2:0] imm);
        return ov(imm, 2'b01, 2'b01, 2'b00, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [19:0] v_trap(input logic [2:0] imm);
        return ov(imm, 2'b00, 2'b00, 2'b00, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic logic [19:0] v_aluwb(input logic [2:0] imm);
        return ov(imm, 2'b00, 2'b00, 2'b00, 1'b0, ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [19:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    // One clock: drive flags, compare at the falling edge, leave just past the rising edge.
    task automatic cycle(input logic rdy, input logic z, input logic lt);
        exp_t e;
        MemReady = rdy; Zero = z; Lt = lt;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed %b required an expected entry", obs_v);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs_v, e.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        check(tag, 20'({IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Fault}), 20'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [3:0] alu);
        logic [1:0] srcb;
        srcb = (o == OP_R) ? 2'b00 : 2'b01;
        set_instr(o, f3, f7);
        push({tag, ".fetch"}, v_fetch(3'b000, 1'b1));
        push({tag, ".decode"}, v_decode(3'b000));
        push({tag, ".exec"}, ov(3'b000, 2'b10, srcb, 2'b00, 1'b0, alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push({tag, ".aluwb"}, v_aluwb(3'b000));
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                              input logic lt, input logic pc_exp);
        set_instr(OP_BR, f3, 1'b0);
        push({tag, ".fetch"}, v_fetch(3'b010, 1'b1));
        push({tag, ".decode"}, v_decode(3'b010));
        push({tag, ".branch"}, ov(3'b010, 2'b10, 2'b00, 2'b00, 1'b0, SUB, 1'b0, pc_exp, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) cycle(1'b1, z, lt);
    endtask

    initial begin
        reset = 1'b1; MemReady = 1'b1; Zero = 1'b0; Lt = 1'b0;
        set_instr(OP_LW, 3'b010, 1'b0);
        @(negedge clk);
        check("reset_hold", 20'({IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Fault}), 20'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // lw with memory always ready: five cycles, RegWrite only in the last.
        push("lw.fetch", v_fetch(3'b000, 1'b1));
        push("lw.decode", v_decode(3'b000));
        push("lw.memadr", ov(3'b000, 2'b10, 2'b01, 2'b00, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("lw.memread", ov(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        push("lw.memwb", ov(3'b000, 2'b00, 2'b00, 2'b01, 1'b0, ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (5) cycle(1'b1, 1'b0, 1'b0);

        // sw: ready arrives on the 4th MEMWRITE cycle, exactly at the wait limit.
        set_instr(OP_SW, 3'b010, 1'b0);
        push("sw.fetch", v_fetch(3'b001, 1'b1));
        push("sw.decode", v_decode(3'b001));
        push("sw.memadr", ov(3'b001, 2'b10, 2'b01, 2'b00, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            push($sformatf("sw.memwrite%0d", i),
                 ov(3'b001, 2'b00, 2'b00, 2'b00, 1'b1, ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        run_alu("r_sub",  OP_R,    3'b000, 1'b1, 4'b0001);
        run_alu("r_add",  OP_R,    3'b000, 1'b0, 4'b0000);
        run_alu("i_add7", OP_IALU, 3'b000, 1'b1, 4'b0000);
        run_alu("r_sra",  OP_R,    3'b101, 1'b1, 4'b1000);
        run_alu("r_srl",  OP_R,    3'b101, 1'b0, 4'b0111);
        run_alu("i_slt",  OP_IALU, 3'b010, 1'b0, 4'b0101);
        run_alu("r_or",   OP_R,    3'b110, 1'b0, 4'b0011);
        run_alu("r_and",  OP_R,    3'b111, 1'b0, 4'b0010);
        run_alu("i_xor",  OP_IALU, 3'b100, 1'b0, 4'b0100);
        run_alu("i_sll",  OP_IALU, 3'b001, 1'b0, 4'b0110);
        run_alu("r_f3u",  OP_R,    3'b011, 1'b1, 4'b0000);

        set_instr(OP_JAL, 3'b000, 1'b0);
        push("jal.fetch", v_fetch(3'b011, 1'b1));
        push("jal.decode", v_decode(3'b011));
        push("jal.jal", ov(3'b011, 2'b01, 2'b10, 2'b00, 1'b0, ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        push("jal.aluwb", v_aluwb(3'b011));
        repeat (4) cycle(1'b1, 1'b0, 1'b0);

        set_instr(OP_JALR, 3'b000, 1'b0);
        push("jalr.fetch", v_fetch(3'b000, 1'b1));
        push("jalr.decode", v_decode(3'b000));
        push("jalr.target", ov(3'b000, 2'b10, 2'b01, 2'b10, 1'b0, ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        push("jalr.link", ov(3'b000, 2'b01, 2'b10, 2'b10, 1'b0, ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (4) cycle(1'b1, 1'b0, 1'b0);

        set_instr(OP_LUI, 3'b000, 1'b0);
        push("lui.fetch", v_fetch(3'b100, 1'b1));
        push("lui.decode", v_decode(3'b100));
        push("lui.lui", ov(3'b100, 2'b11, 2'b01, 2'b00, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("lui.aluwb", v_aluwb(3'b100));
        repeat (4) cycle(1'b1, 1'b0, 1'b0);

        run_branch("beq_z0", 3'b000, 1'b0, 1'b0, 1'b0);
        run_branch("beq_z1", 3'b000, 1'b1, 1'b0, 1'b1);
`ifdef MCTRL_BRANCH_EXT_EN
        run_branch("bne_z0", 3'b001, 1'b0, 1'b0, 1'b1);
        run_branch("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0);
        run_branch("blt_l1", 3'b100, 1'b0, 1'b1, 1'b1);
        run_branch("bge_l1", 3'b101, 1'b0, 1'b1, 1'b0);
`else
        set_instr(OP_BR, 3'b001, 1'b0);
        push("bne.fetch", v_fetch(3'b010, 1'b1));
        push("bne.decode", v_decode(3'b010));
        push("bne.trap0", v_trap(3'b010));
        push("bne.trap1", v_trap(3'b010));
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        do_reset("bne.reset");
`endif

        // Fetch never acknowledged: four wait cycles then a sticky TRAP.
        set_instr(OP_LW, 3'b010, 1'b0);
        for (int i = 0; i < 4; i++) push($sformatf("to.fetch%0d", i), v_fetch(3'b000, 1'b0));
        for (int i = 0; i < 3; i++) push($sformatf("to.trap%0d", i), v_trap(3'b000));
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        do_reset("to.reset");

        // Undefined opcode traps from DECODE.
        set_instr(7'b0000000, 3'b000, 1'b0);
        push("ill.fetch", v_fetch(3'b000, 1'b1));
        push("ill.decode", v_decode(3'b000));
        push("ill.trap", v_trap(3'b000));
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        do_reset("ill.reset");

        // Reset in the middle of MEMREAD, then a fresh wait budget in FETCH.
        set_instr(OP_LW, 3'b010, 1'b0);
        push("mr.fetch", v_fetch(3'b000, 1'b1));
        push("mr.decode", v_decode(3'b000));
        push("mr.memadr", ov(3'b000, 2'b10, 2'b01, 2'b00, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push("mr.memread", ov(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        do_reset("mr.reset");
        for (int i = 0; i < 3; i++) push($sformatf("mr.refetch%0d", i), v_fetch(3'b000, 1'b0));
        push("mr.refetch3", v_fetch(3'b000, 1'b1));
        push("mr.redecode", v_decode(3'b000));
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
